// File: rtl/mem_fifo_buffer.sv
// mem_fifo_buffer: parametrised synchronous FIFO with a registered read port,
// fill level, full/empty, programmable almost-full/almost-empty thresholds and
// sticky overflow/underflow flags. Rate-decoupling buffer between the
// FSM/mux datapath and downstream consumers.
module mem_fifo_buffer #(
   parameter int unsigned WORD_SIZE        = 4,
   parameter int unsigned ADDR_WIDTH       = 2,
   parameter int unsigned ALMOST_FULL_LVL  = 3,
   parameter int unsigned ALMOST_EMPTY_LVL = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [WORD_SIZE-1:0]  data_in,
   input  logic                  rd_en,
   output logic [WORD_SIZE-1:0]  data_out,
   output logic                  valid_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   fill_level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   // Thresholds sized to the counter so the decodes compare equal widths.
   localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] AF_CNT   = ALMOST_FULL_LVL[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AE_CNT   = ALMOST_EMPTY_LVL[ADDR_WIDTH:0];

   logic [WORD_SIZE-1:0]  mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   fill_next;
   logic                  wr_acc;
   logic                  rd_acc;

   // Status flags decode the registered count only.
   assign full         = (fill_level == FULL_CNT);
   assign empty        = (fill_level == '0);
   assign almost_full  = (fill_level >= AF_CNT);
   assign almost_empty = (fill_level <= AE_CNT);

   // A full FIFO still takes a write when the same edge pops a word.
   assign rd_acc = rd_en && !empty;
   assign wr_acc = wr_en && (!full || rd_acc);

   // Count update: simultaneous push and pop cancel out.
   always_comb begin
      fill_next = fill_level;
      unique case ({wr_acc, rd_acc})
         2'b10:   fill_next = fill_level + 1'b1;
         2'b01:   fill_next = fill_level - 1'b1;
         default: fill_next = fill_level;
      endcase
   end

   // Storage array: no reset, contents are unobservable while empty.
   always_ff @(posedge clk) begin
      if (reset && wr_acc) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointers, count, registered read port and sticky error flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         fill_level <= fill_next;
         valid_out  <= rd_acc;
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr   <= rd_ptr + 1'b1;
            data_out <= mem[rd_ptr];
         end
         if (wr_en && !wr_acc) begin
            overflow <= 1'b1;
         end
         if (rd_en && !rd_acc) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_fifo_buffer.sv
// Scoreboard bench for mem_fifo_buffer: stimulus pushes the hand-computed word
// each accepted pop must return; a negedge monitor pops and compares whenever
// valid_out is high. Status outputs are checked directly after each edge.
module tb_mem_fifo_buffer;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en = 1'b0;
   logic [3:0] data_in = 4'h0;
   logic       rd_en = 1'b0;
   logic [3:0] data_out;
   logic       valid_out;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [2:0] fill_level;
   logic       overflow;
   logic       underflow;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [3:0]  exp_q[$];

   mem_fifo_buffer #(
      .WORD_SIZE        (4),
      .ADDR_WIDTH       (2),
      .ALMOST_FULL_LVL  (3),
      .ALMOST_EMPTY_LVL (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .data_in      (data_in),
      .rd_en        (rd_en),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .fill_level   (fill_level),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: every valid_out pulse must match the oldest expected word.
   always @(negedge clk) begin
      if (reset === 1'b1 && valid_out === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got %0h expected no valid_out", data_out);
         end else begin
            chk("pop_data", {28'h0, data_out}, {28'h0, exp_q.pop_front()});
         end
      end
   end

   // One clock of stimulus; exp_pop queues the word an accepted read must return.
   task automatic op(input logic w, input logic [3:0] d, input logic r,
                     input logic exp_pop, input logic [3:0] exp_val);
      wr_en   = w;
      data_in = d;
      rd_en   = r;
      if (exp_pop) exp_q.push_back(exp_val);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic status(input string tag, input logic [2:0] lvl, input logic f,
                         input logic e, input logic af, input logic ae);
      chk({tag, "_fill"},  {29'h0, fill_level}, {29'h0, lvl});
      chk({tag, "_full"},  {31'h0, full},         {31'h0, f});
      chk({tag, "_empty"}, {31'h0, empty},        {31'h0, e});
      chk({tag, "_af"},    {31'h0, almost_full},  {31'h0, af});
      chk({tag, "_ae"},    {31'h0, almost_empty}, {31'h0, ae});
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #2 reset = 1'b0;
      #1 reset = 1'b1;
      #1;
   endtask

   // Hard bound on run time.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      #1 reset = 1'b0;
      // Reset holds everything despite write attempts.
      wr_en   = 1'b1;
      data_in = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      status("rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("rst_data",  {28'h0, data_out}, 32'h0);
      chk("rst_valid", {31'h0, valid_out}, 32'h0);
      chk("rst_ovf",   {31'h0, overflow},  32'h0);
      chk("rst_unf",   {31'h0, underflow}, 32'h0);
      reset = 1'b1;
      wr_en = 1'b0;
      op(1'b1, 4'hF, 1'b0, 1'b0, 4'h0);
      chk("post_rst_fill", {29'h0, fill_level}, 32'd1);
      op(1'b0, 4'h0, 1'b1, 1'b1, 4'hF);
      status("post_rst_pop", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

      // Fill 1..4 with threshold checks.
      op(1'b1, 4'h1, 1'b0, 1'b0, 4'h0);
      status("fill1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      op(1'b1, 4'h2, 1'b0, 1'b0, 4'h0);
      status("fill2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      op(1'b1, 4'h3, 1'b0, 1'b0, 4'h0);
      status("fill3", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      op(1'b1, 4'h4, 1'b0, 1'b0, 4'h0);
      status("fill4", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);

      // Write into a full FIFO is dropped.
      op(1'b1, 4'hA, 1'b0, 1'b0, 4'h0);
      chk("ovf_set",  {31'h0, overflow}, 32'h1);
      chk("ovf_fill", {29'h0, fill_level}, 32'd4);

      // Drain; A must never appear.
      op(1'b0, 4'h0, 1'b1, 1'b1, 4'h1);
      op(1'b0, 4'h0, 1'b1, 1'b1, 4'h2);
      op(1'b0, 4'h0, 1'b1, 1'b1, 4'h3);
      op(1'b0, 4'h0, 1'b1, 1'b1, 4'h4);
      status("drained", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

      // Read from an empty FIFO.
      op(1'b0, 4'h0, 1'b1, 1'b0, 4'h0);
      chk("unf_set",   {31'h0, underflow}, 32'h1);
      chk("unf_data",  {28'h0, data_out}, 32'h4);
      chk("unf_valid", {31'h0, valid_out}, 32'h0);
      repeat (2) op(1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
      chk("ovf_sticky", {31'h0, overflow},  32'h1);
      chk("unf_sticky", {31'h0, underflow}, 32'h1);
      chk("hold_data",  {28'h0, data_out}, 32'h4);

      // Simultaneous push/pop on a full FIFO.
      reset_pulse();
      chk("flags_clr", {30'h0, overflow, underflow}, 32'h0);
      op(1'b1, 4'h1, 1'b0, 1'b0, 4'h0);
      op(1'b1, 4'h2, 1'b0, 1'b0, 4'h0);
      op(1'b1, 4'h3, 1'b0, 1'b0, 4'h0);
      op(1'b1, 4'h4, 1'b0, 1'b0, 4'h0);
      op(1'b1, 4'h9, 1'b1, 1'b1, 4'h1);
      chk("full_rw_fill", {29'h0, fill_level}, 32'd4);
      chk("full_rw_ovf",  {31'h0, overflow}, 32'h0);
      op(1'b0, 4'h0, 1'b1, 1'b1, 4'h2);
      op(1'b0, 4'h0, 1'b1, 1'b1, 4'h3);
      op(1'b0, 4'h0, 1'b1, 1'b1, 4'h4);
      op(1'b0, 4'h0, 1'b1, 1'b1, 4'h9);

      // Simultaneous push/pop on an empty FIFO: write only.
      op(1'b1, 4'h5, 1'b1, 1'b0, 4'h0);
      chk("empty_rw_fill",  {29'h0, fill_level}, 32'd1);
      chk("empty_rw_unf",   {31'h0, underflow}, 32'h1);
      chk("empty_rw_valid", {31'h0, valid_out}, 32'h0);
      op(1'b0, 4'h0, 1'b1, 1'b1, 4'h5);

      // Wrap-around: pointers roll 3->0 twice.
      reset_pulse();
      for (int i = 0; i < 10; i++) begin
         op(1'b1, 4'(i), 1'b0, 1'b0, 4'h0);
         op(1'b0, 4'h0, 1'b1, 1'b1, 4'(i));
      end
      chk("wrap_fill", {29'h0, fill_level}, 32'd0);

      // Asynchronous reset with three words stored.
      op(1'b1, 4'hB, 1'b0, 1'b0, 4'h0);
      op(1'b1, 4'hC, 1'b0, 1'b0, 4'h0);
      op(1'b0, 4'h0, 1'b1, 1'b1, 4'hB);
      op(1'b1, 4'hD, 1'b0, 1'b0, 4'h0);
      op(1'b1, 4'hE, 1'b0, 1'b0, 4'h0);
      chk("pre_arst_fill", {29'h0, fill_level}, 32'd3);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_fill",  {29'h0, fill_level}, 32'd0);
      chk("arst_empty", {31'h0, empty}, 32'h1);
      chk("arst_data",  {28'h0, data_out}, 32'h0);
      reset = 1'b1;
      #1;
      op(1'b0, 4'h0, 1'b1, 1'b0, 4'h0);
      chk("arst_unf",   {31'h0, underflow}, 32'h1);
      chk("arst_valid", {31'h0, valid_out}, 32'h0);

      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
